// File: rtl/inst_prefetch_queue_if.sv
// rtl/inst_prefetch_queue_if.sv - ROM fetch and ID handoff signals of the instruction prefetch queue
interface inst_prefetch_queue_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 3
);
    logic          ice;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] inst;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          id_valid;
    logic [AW-1:0] id_pc;
    logic [DW-1:0] id_inst;
    logic          id_ready;
    logic [CW-1:0] count;

    modport master (
        output ice, iaddr, id_valid, id_pc, id_inst, count,
        input  inst, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  ice, iaddr, id_valid, id_pc, id_inst, count,
        output inst, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - DEPTH-entry instruction prefetch queue between the ROM and ID
module inst_prefetch_queue #(
    parameter int            DEPTH    = 4,
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst,
    inst_prefetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

    logic [AW-1:0] fpc;
    logic [AW-1:0] rq_pc;
    logic [PW-1:0] rp;
    logic [PW-1:0] wp;
    logic [CW-1:0] cnt;
    logic          inflight;
    logic [AW-1:0] pc_mem   [DEPTH];
    logic [DW-1:0] inst_mem [DEPTH];

    logic [CW:0] credit;
    logic        pop;
    logic        push;
    logic        issue;

    // Credit counts the outstanding read so a full queue can only refill through a pop.
    assign credit = {1'b0, cnt} + (CW+1)'(inflight);
    assign pop    = (cnt != '0) && bus.id_ready;
    assign push   = inflight && !bus.redirect;
    assign issue  = !cpu_rst && !bus.redirect &&
                    ((credit < FULL) || ((credit == FULL) && pop));

    assign bus.ice      = issue;
    assign bus.iaddr    = fpc;
    assign bus.id_valid = (cnt != '0);
    assign bus.id_pc    = pc_mem[rp];
    assign bus.id_inst  = inst_mem[rp];
    assign bus.count    = cnt;

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            fpc      <= RESET_PC;
            rq_pc    <= '0;
            rp       <= '0;
            wp       <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (bus.redirect) begin
            // Any response arriving now belongs to the old stream and is dropped.
            fpc      <= bus.redirect_pc;
            rp       <= '0;
            wp       <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fpc   <= fpc + AW'(4);
                rq_pc <= fpc;
            end
            if (push) begin
                pc_mem[wp]   <= rq_pc;
                inst_mem[wp] <= bus.inst;
                wp           <= wp + PW'(1);
            end
            if (pop) begin
                rp <= rp + PW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb/tb_inst_prefetch_queue.sv - scoreboard bench for inst_prefetch_queue at DEPTH 4 and DEPTH 2
module tb_inst_prefetch_queue;
    localparam logic [31:0] XMASK = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_q  [$];
    logic [31:0] exp2_q [$];

    inst_prefetch_queue_if #(.AW(32), .DW(32), .CW(3)) bus  ();
    inst_prefetch_queue_if #(.AW(32), .DW(32), .CW(2)) bus2 ();

    inst_prefetch_queue #(.DEPTH(4), .AW(32), .DW(32), .RESET_PC(32'h0)) u_dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .bus         (bus)
    );

    inst_prefetch_queue #(.DEPTH(2), .AW(32), .DW(32), .RESET_PC(32'h0)) u_dut2 (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .bus         (bus2)
    );

    always #5 clk = ~clk;

    // Synchronous ROM models: data appears one cycle after the read enable.
    always @(posedge clk) begin
        if (bus.ice)  bus.inst  <= bus.iaddr ^ XMASK;
        if (bus2.ice) bus2.inst <= bus2.iaddr ^ XMASK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic sb_load(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic sb2_load();
        exp2_q.delete();
        for (int i = 0; i < 64; i++) exp2_q.push_back(32'(4 * i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset, check reset outputs, release just after an edge: caller is at start of cycle 0.
    task automatic apply_reset();
        rst = 1'b1;
        sb_load(32'h0);
        sb2_load();
        @(negedge clk);
        chk("rst_ice", 32'(bus.ice), 32'd0);
        chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_id_pc", bus.id_pc, 32'h0);
        chk("rst_id_inst", bus.id_inst, 32'h0);
        chk("rst_iaddr", bus.iaddr, 32'h0);
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.id_valid && bus.id_ready && !bus.redirect) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", bus.id_pc, 32'hDEAD_BEEF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_id_pc", bus.id_pc, e);
                chk("sb_id_inst", bus.id_inst, e ^ XMASK);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("d2_count_le_2", 32'(bus2.count > 2'd2), 32'd0);
            if (bus2.id_valid && bus2.id_ready) begin
                if (exp2_q.size() == 0) begin
                    chk("sb2_empty", bus2.id_pc, 32'hDEAD_BEEF);
                end else begin
                    logic [31:0] e;
                    e = exp2_q.pop_front();
                    chk("sb2_id_pc", bus2.id_pc, e);
                    chk("sb2_id_inst", bus2.id_inst, e ^ XMASK);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] fill_cnt [8];
        fill_cnt = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};

        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus.id_ready     = 1'b1;
        bus2.redirect    = 1'b0;
        bus2.redirect_pc = '0;
        bus2.id_ready    = 1'b0;

        // Reset and stream
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("s_ice", 32'(bus.ice), 32'd1);
            chk("s_iaddr", bus.iaddr, 32'(4 * i));
            chk("s_id_valid", 32'(bus.id_valid), (i >= 2) ? 32'd1 : 32'd0);
            chk("s_count", 32'(bus.count), (i >= 2) ? 32'd1 : 32'd0);
            tick();
        end

        // Redirect with a read in flight (cycle 6)
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        sb_load(32'h100);
        @(negedge clk);
        chk("r_ice_in_redirect", 32'(bus.ice), 32'd0);
        chk("r_id_valid_ungated", 32'(bus.id_valid), 32'd1);
        tick();
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("r1_count", 32'(bus.count), 32'd0);
        chk("r1_ice", 32'(bus.ice), 32'd1);
        chk("r1_iaddr", bus.iaddr, 32'h100);
        chk("r1_id_valid", 32'(bus.id_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("r2_id_valid", 32'(bus.id_valid), 32'd0);
        chk("r2_iaddr", bus.iaddr, 32'h104);
        tick();
        @(negedge clk);
        chk("r3_id_valid", 32'(bus.id_valid), 32'd1);
        chk("r3_id_pc", bus.id_pc, 32'h100);
        repeat (6) tick();

        // Backpressure to full
        bus.id_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp_ice", 32'(bus.ice), (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) chk("bp_iaddr", bus.iaddr, 32'(4 * i));
            chk("bp_count", 32'(bus.count), 32'(fill_cnt[i]));
            tick();
        end
        bus.id_ready = 1'b1;
        #1;
        chk("bp_ice_on_ready", 32'(bus.ice), 32'd1);
        chk("bp_iaddr_on_ready", bus.iaddr, 32'd16);
        repeat (12) tick();

        // Redirect while full with a coincident pop
        bus.id_ready = 1'b0;
        apply_reset();
        repeat (8) tick();
        bus.id_ready    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        sb_load(32'h200);
        #1;
        chk("f_ice_in_redirect", 32'(bus.ice), 32'd0);
        @(negedge clk);
        chk("f_count_before", 32'(bus.count), 32'd4);
        tick();
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("f1_count", 32'(bus.count), 32'd0);
        chk("f1_ice", 32'(bus.ice), 32'd1);
        chk("f1_iaddr", bus.iaddr, 32'h200);
        tick();
        tick();
        @(negedge clk);
        chk("f3_id_valid", 32'(bus.id_valid), 32'd1);
        chk("f3_id_pc", bus.id_pc, 32'h200);
        repeat (6) tick();

        // Asynchronous reset mid-run at count 3
        bus.id_ready = 1'b0;
        apply_reset();
        repeat (4) tick();
        #1;
        chk("ar_count_before", 32'(bus.count), 32'd3);
        rst = 1'b1;
        sb_load(32'h0);
        sb2_load();
        #1;
        chk("ar_id_valid", 32'(bus.id_valid), 32'd0);
        chk("ar_count", 32'(bus.count), 32'd0);
        chk("ar_ice", 32'(bus.ice), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ar_restart_ice", 32'(bus.ice), 32'd1);
        chk("ar_restart_iaddr", bus.iaddr, 32'h0);
        tick();

        // Pointer wrap on the DEPTH=2 instance
        bus.id_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            bus2.id_ready = (i % 2 == 0);
            tick();
        end
        bus2.id_ready = 1'b0;
        @(negedge clk);
        chk("w_fetch_advanced", 32'(bus2.iaddr > 32'd40), 32'd1);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inst_prefetch_queue.md
# inst_prefetch_queue

- Parametrised instruction-fetch front end that sits between the synchronous instruction ROM and the ID stage.
- Replaces the single-entry IF/ID handoff with a DEPTH-entry queue. Instructions are fetched ahead of decode and handed to ID over a valid/ready handshake.
- A redirect (branch, jump or exception target) flushes all queued and in-flight instructions.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2
- AW, 32, instruction address width
- DW, 32, instruction word width
- RESET_PC, 0, first fetch address after reset

Ports:
- cpu_clk_50M  in  1  clock; all state updates on the rising edge
- cpu_rst  in  1  reset, asynchronous, active-high
- ice  out  1  ROM read enable
- iaddr  out  AW  ROM read address; word-aligned
- inst  in  DW  ROM read data; valid exactly one cycle after the cycle in which ice=1
- redirect  in  1  single-cycle request to flush the queue and refetch
- redirect_pc  in  AW  new fetch address, sampled when redirect=1
- id_valid  out  1  queue head holds a valid instruction
- id_pc  out  AW  PC of the queue head
- id_inst  out  DW  instruction at the queue head
- id_ready  in  1  ID accepts the head; a transfer occurs when id_valid && id_ready
- count  out  log2(DEPTH)+1  number of valid queue entries

## Operation
State:
- fpc: next fetch address
- Circular storage of {pc, inst}, with read pointer rp and write pointer wp, each log2(DEPTH) bits and wrapping modulo DEPTH
- count
- inflight: 1 bit, a ROM read is outstanding
- rq_pc: PC of the outstanding read

Fetch issue (combinational):
- ice = !redirect && (count + inflight < DEPTH || (count + inflight == DEPTH && pop)), where pop = id_valid && id_ready.
- iaddr = fpc.
- On issue: fpc <= fpc + 4 (wraps modulo 2^AW), rq_pc <= fpc, inflight <= 1. Otherwise inflight <= 0.

Response:
- When inflight=1 and no redirect, {rq_pc, inst} is written at wp and wp increments.
- Because of the credit rule in the issue logic, the queue never overflows.

Output and pop:
- id_valid = (count != 0).
- id_pc and id_inst come from entry rp.
- On pop, rp increments.

Count update:
- count <= count + push - pop.
- Simultaneous push and pop leave count unchanged.
- Push and pop while count == DEPTH is legal, because the issue credit included the pop.

Redirect (highest priority):
- Next cycle values: count=0, rp=wp=0, inflight=0, fpc=redirect_pc.
- The response for any read in flight is discarded.
- ice=0 in the redirect cycle.
- A pop coincident with redirect is discarded. id_valid is not gated by redirect; ID must squash that instruction itself.
- If redirect is held for several cycles, the last redirect_pc wins.

Reset (asynchronous, active-high):
- fpc=RESET_PC, count=0, rp=wp=0, inflight=0, rq_pc=0, storage contents don't-care.
- Output values during reset: ice=0, id_valid=0, count=0, id_pc=0, id_inst=0 (entry 0 is cleared), iaddr=RESET_PC.
- Asserting reset mid-operation discards queued and in-flight instructions immediately.

## Timing
- Fetch-to-ID latency is 2 cycles:
  - cycle N: ice=1, iaddr=A
  - cycle N+1: inst valid, written at the end of the cycle
  - cycle N+2: id_valid=1, id_pc=A
- Sustained throughput is 1 instruction per cycle when id_ready=1 continuously, for any DEPTH ≥ 2.
- First fetch: the first cycle after reset deasserts drives ice=1 with iaddr=RESET_PC.
- Redirect penalty:
  - redirect in cycle R
  - fetch of redirect_pc in cycle R+1
  - id_valid at redirect_pc in cycle R+3
- There is no combinational path from inst to any output. id_ready and redirect reach ice combinationally.

## Test plan
- **Reset and stream:** deassert cpu_rst with id_ready=1 and ROM returning inst=pc ^ 32'hFFFF_0000 → iaddr sequence 0, 4, 8, … one per cycle; id_valid first rises 2 cycles after the first ice; id_pc 0, 4, 8, … consecutive with no bubbles; count stays ≤1.
- **Backpressure to full:** DEPTH=4, id_ready=0 → exactly 4 ROM reads issued; count=4; ice=0 thereafter. Then raise id_ready → ice reasserts in the same cycle; PCs 0, 4, 8, 12, 16, … are delivered in order with none lost or duplicated.
- **Redirect with in-flight read:** while streaming, pulse redirect with redirect_pc=32'h100 in the same cycle as an issue response → count=0 next cycle; the stale response is not enqueued; next iaddr=32'h100; next id_pc=32'h100 at R+3.
- **Redirect while full and id_ready=1:** redirect at count=4 with a coincident pop → count=0 next cycle; the first subsequent id_pc equals redirect_pc.
- **Pointer wrap:** DEPTH=2, toggle id_ready 1/0 every cycle for 20 cycles → every PC is delivered exactly once in ascending order; count never exceeds 2.
- **Asynchronous reset mid-run:** assert cpu_rst between clock edges with count=3 → id_valid=0, count=0 and ice=0 immediately. After release, fetching restarts at RESET_PC.
